// File: rtl/fwd_sel_unit.sv
// Operand-forwarding control for the EX stage.
// Tracks destination tags of in-flight instructions and produces registered
// 4:1 operand-mux selects for the instruction entering EX. It also flags
// load-use hazards so that ID holds and EX takes a bubble.
module fwd_sel_unit #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_is_load,
   input  logic              hold,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              load_use_stall
);

   localparam logic [REG_AW-1:0] ZeroReg  = REG_AW'(ZERO_REG);
   // Slot order, youngest first: EX, MEM, WB, RET.
   localparam int unsigned       NumSlots = 4;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              is_load;
   } slot_t;

   // Values match the operand-mux data input order.
   typedef enum logic [1:0] {
      SelRegFile = 2'b00,
      SelExMem   = 2'b01,
      SelMemWb   = 2'b10,
      SelRetired = 2'b11
   } sel_e;

   slot_t slot_q [NumSlots];
   slot_t slot_d [NumSlots];
   sel_e  sel_a_q, sel_a_d;
   sel_e  sel_b_q, sel_b_d;
   sel_e  sel_a_new, sel_b_new;
   logic  ex_is_load;
   logic  ex_hits_rs;

   // A slot produces register r only if it is a live writer of a real register.
   function automatic logic slot_writes(input slot_t s, input logic [REG_AW-1:0] r);
      return s.valid && s.regwrite && (s.rd == r) && (r != ZeroReg);
   endfunction

   // Youngest-first search. The select names where the value sits once the
   // consumer is in EX, so each producer is one stage further down by then.
   function automatic sel_e search(input slot_t ex, input slot_t mem, input slot_t wb,
                                   input logic [REG_AW-1:0] rs);
      sel_e sel;
      if (slot_writes(ex, rs)) begin
         sel = SelExMem;
      end else if (slot_writes(mem, rs)) begin
         sel = SelMemWb;
      end else if (slot_writes(wb, rs)) begin
         sel = SelRetired;
      end else begin
         sel = SelRegFile;
      end
      return sel;
   endfunction

   // Candidate selects for the ID instruction against the current slots.
   always_comb begin
      sel_a_new = search(slot_q[0], slot_q[1], slot_q[2], id_rs1);
      sel_b_new = search(slot_q[0], slot_q[1], slot_q[2], id_rs2);
   end

   // Load-use hazard: the load in EX cannot forward in time to the next EX.
   always_comb begin
      ex_is_load     = slot_q[0].valid && slot_q[0].is_load && slot_q[0].regwrite
                       && (slot_q[0].rd != ZeroReg);
      ex_hits_rs     = (slot_q[0].rd == id_rs1) || (slot_q[0].rd == id_rs2);
      load_use_stall = id_valid && ex_is_load && ex_hits_rs && !hold && !flush;
   end

   // Next-state: hold freezes everything; flush and stall insert a bubble.
   always_comb begin
      slot_d  = slot_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      if (!hold) begin
         // Older instructions always advance, even on flush or stall.
         for (int i = NumSlots - 1; i > 0; i--) begin
            slot_d[i] = slot_q[i-1];
         end
         if (flush || load_use_stall) begin
            slot_d[0] = '0;
            sel_a_d   = SelRegFile;
            sel_b_d   = SelRegFile;
         end else begin
            slot_d[0] = '{valid:    id_valid,
                          rd:       id_rd,
                          regwrite: id_regwrite,
                          is_load:  id_is_load};
            sel_a_d   = id_valid ? sel_a_new : SelRegFile;
            sel_b_d   = id_valid ? sel_b_new : SelRegFile;
         end
      end
   end

   // Slot tags and registered selects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumSlots; i++) begin
            slot_q[i] <= '0;
         end
         sel_a_q <= SelRegFile;
         sel_b_q <= SelRegFile;
      end else begin
         slot_q  <= slot_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   // Drive the mux selects straight from the registers.
   always_comb begin
      fwd_a_sel = sel_a_q;
      fwd_b_sel = sel_b_q;
   end

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Bench for fwd_sel_unit: directed scenarios followed by random traffic. Every
// cycle is checked against a history-list reference model.
module tb_fwd_sel_unit;

   typedef struct {
      bit         v;
      logic [4:0] rd;
      bit         rw;
      bit         ld;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic [4:0] id_rd = '0;
   logic       id_regwrite = 1'b0;
   logic       id_is_load = 1'b0;
   logic       hold = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       load_use_stall;

   // History of instructions issued into EX, youngest at index 0.
   instr_t     hist[$];
   logic [1:0] exp_a = 2'b00;
   logic [1:0] exp_b = 2'b00;
   int         total = 0;
   int         bad = 0;

   fwd_sel_unit #(
      .REG_AW  (5),
      .ZERO_REG(0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .id_regwrite   (id_regwrite),
      .id_is_load    (id_is_load),
      .hold          (hold),
      .flush         (flush),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Distance back in history of the youngest writer gives the select.
   function automatic logic [1:0] model_sel(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      for (int k = 0; k < 3; k++) begin
         if (k < hist.size() && hist[k].v && hist[k].rw && hist[k].rd == rs)
            return 2'(k + 1);
      end
      return 2'b00;
   endfunction

   function automatic bit model_stall();
      if (hold || flush || !id_valid || hist.size() == 0) return 1'b0;
      return hist[0].v && hist[0].ld && hist[0].rw && hist[0].rd != 5'd0 &&
             (hist[0].rd == id_rs1 || hist[0].rd == id_rs2);
   endfunction

   function automatic void model_advance();
      bit         st;
      logic [1:0] na;
      logic [1:0] nb;
      st = model_stall();
      na = model_sel(id_rs1);
      nb = model_sel(id_rs2);
      if (hold) return;
      if (flush || st) begin
         hist.push_front(instr_t'{1'b0, 5'd0, 1'b0, 1'b0});
         exp_a = 2'b00;
         exp_b = 2'b00;
      end else begin
         hist.push_front(instr_t'{id_valid, id_rd, id_regwrite, id_is_load});
         exp_a = id_valid ? na : 2'b00;
         exp_b = id_valid ? nb : 2'b00;
      end
      if (hist.size() > 4) void'(hist.pop_back());
   endfunction

   // Present one ID cycle, check before and after the clock edge.
   task automatic issue(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit rw, input bit ld,
                        input bit h, input bit f, input string tag);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_regwrite = rw;
      id_is_load  = ld;
      hold        = h;
      flush       = f;
      #1;
      check({tag, "/stall"}, {1'b0, load_use_stall}, {1'b0, model_stall()});
      check({tag, "/a_pre"}, fwd_a_sel, exp_a);
      check({tag, "/b_pre"}, fwd_b_sel, exp_b);
      @(posedge clk);
      model_advance();
      #1;
      check({tag, "/a"}, fwd_a_sel, exp_a);
      check({tag, "/b"}, fwd_b_sel, exp_b);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "drain");
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", fwd_a_sel, 2'b00);
      check("reset_b", fwd_b_sel, 2'b00);
      check("reset_stall", {1'b0, load_use_stall}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back ALU dependency.
      issue(1, 0, 0, 3, 1, 0, 0, 0, "b2b_i1");
      issue(1, 3, 3, 1, 1, 0, 0, 0, "b2b_i2");
      check("b2b_a01", fwd_a_sel, 2'b01);
      check("b2b_b01", fwd_b_sel, 2'b01);
      drain();

      // Distance 2 on A, distance 1 on B.
      issue(1, 0, 0, 4, 1, 0, 0, 0, "d2_i1");
      issue(1, 0, 0, 7, 1, 0, 0, 0, "d2_i2");
      issue(1, 4, 7, 1, 0, 0, 0, 0, "d2_i3");
      check("d2_a10", fwd_a_sel, 2'b10);
      check("d2_b01", fwd_b_sel, 2'b01);
      drain();

      // Distance 3 through two nops.
      issue(1, 0, 0, 4, 1, 0, 0, 0, "d3_i1");
      issue(1, 0, 0, 0, 0, 0, 0, 0, "d3_nop");
      issue(1, 0, 0, 0, 0, 0, 0, 0, "d3_nop");
      issue(1, 4, 0, 2, 0, 0, 0, 0, "d3_i4");
      check("d3_a11", fwd_a_sel, 2'b11);
      drain();

      // Youngest writer wins.
      issue(1, 0, 0, 4, 1, 0, 0, 0, "yw_i1");
      issue(1, 0, 0, 4, 1, 0, 0, 0, "yw_i2");
      issue(1, 4, 0, 0, 0, 0, 0, 0, "yw_i3");
      check("yw_a01", fwd_a_sel, 2'b01);
      drain();

      // Load-use: one stall cycle, then forward from MEM/WB.
      issue(1, 0, 0, 6, 1, 1, 0, 0, "lu_load");
      id_valid = 1; id_rs1 = 0; id_rs2 = 6; id_rd = 1; id_regwrite = 1; id_is_load = 0;
      #1;
      check("lu_stall_on", {1'b0, load_use_stall}, 2'b01);
      issue(1, 0, 6, 1, 1, 0, 0, 0, "lu_i2_stalled");
      check("lu_bubble_b", fwd_b_sel, 2'b00);
      check("lu_stall_off", {1'b0, load_use_stall}, 2'b00);
      issue(1, 0, 6, 1, 1, 0, 0, 0, "lu_i2_enter");
      check("lu_b10", fwd_b_sel, 2'b10);
      drain();

      // x0 never forwards or stalls; bubbles never match.
      issue(1, 0, 0, 0, 1, 0, 0, 0, "x0_i1");
      issue(1, 0, 0, 2, 0, 0, 0, 0, "x0_i2");
      check("x0_a00", fwd_a_sel, 2'b00);
      issue(1, 0, 0, 0, 1, 1, 0, 0, "x0_load");
      id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_regwrite = 0; id_is_load = 0;
      #1;
      check("x0_nostall", {1'b0, load_use_stall}, 2'b00);
      issue(0, 0, 0, 9, 1, 0, 0, 0, "bub_i1");
      issue(1, 9, 9, 0, 0, 0, 0, 0, "bub_i2");
      check("bub_a00", fwd_a_sel, 2'b00);
      check("bub_b00", fwd_b_sel, 2'b00);
      drain();

      // Hold during a pending load-use forward.
      issue(1, 0, 0, 0, 1, 0, 0, 0, "hold_pre");
      issue(1, 0, 0, 0, 0, 0, 0, 0, "hold_pre2");
      issue(1, 0, 0, 8, 1, 1, 0, 0, "hold_load");
      for (int i = 0; i < 3; i++) begin
         issue(1, 8, 0, 1, 1, 0, 1, 0, "hold_frz");
         check("hold_nostall", {1'b0, load_use_stall}, 2'b00);
         check("hold_a_frz", fwd_a_sel, 2'b00);
      end
      hold = 1'b0;
      #1;
      check("hold_release_stall", {1'b0, load_use_stall}, 2'b01);
      issue(1, 8, 0, 1, 1, 0, 0, 0, "hold_rel");
      issue(1, 8, 0, 1, 1, 0, 0, 0, "hold_enter");
      check("hold_a10", fwd_a_sel, 2'b10);
      drain();

      // Flush with a load-use condition present.
      issue(1, 0, 0, 6, 1, 1, 0, 0, "fl_load");
      issue(1, 6, 0, 1, 1, 0, 0, 1, "fl_flush");
      check("fl_a00", fwd_a_sel, 2'b00);
      id_flush_clear: begin
         flush = 1'b0;
         #1;
         check("fl_ex_invalid", {1'b0, load_use_stall}, 2'b00);
      end
      issue(1, 6, 0, 1, 1, 0, 0, 0, "fl_after");
      drain();

      // Reset mid-stream with EX holding rd=5.
      issue(1, 0, 0, 5, 1, 1, 0, 0, "rst_i1");
      id_valid = 1; id_rs1 = 5; id_rs2 = 5; hold = 0; flush = 0;
      rst_n = 1'b0;
      hist.delete();
      exp_a = 2'b00;
      exp_b = 2'b00;
      #1;
      check("rst_mid_a", fwd_a_sel, 2'b00);
      check("rst_mid_b", fwd_b_sel, 2'b00);
      check("rst_mid_stall", {1'b0, load_use_stall}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      issue(1, 5, 0, 1, 0, 0, 0, 0, "rst_after");
      check("rst_after_a00", fwd_a_sel, 2'b00);

      // Random traffic on a small register range to provoke hits.
      for (int n = 0; n < 400; n++) begin
         issue(bit'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
               bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 9) == 0),
               "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_sel_unit.md
Name: fwd_sel_unit

Overview:
- Operand-forwarding control for the RISC-V EX stage.
- Sits directly upstream of the 2-bit-select 4:1 operand muxes. It drives each mux's select, one mux for ALU operand A and one for operand B.
- Keeps a shadow pipeline of destination-register and write-enable tags for the EX, MEM, WB and retired slots. From these it produces registered select codes for the instruction entering EX.
- Detects load-use hazards and requests a one-cycle stall.

Parameters:
- REG_AW, 5, register-address width.
- ZERO_REG, 0, hard-wired zero register index; never forwarded.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_AW  source register 1 of ID instruction
- id_rs2  in  REG_AW  source register 2 of ID instruction
- id_rd  in  REG_AW  destination register of ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- hold  in  1  global freeze (memory wait); all state holds
- flush  in  1  branch redirect; kill ID and EX slots
- fwd_a_sel  out  2  operand-A mux select for instruction in EX
- fwd_b_sel  out  2  operand-B mux select for instruction in EX
- load_use_stall  out  1  ID must hold and EX receives a bubble

Behaviour:
Reset:
- Asynchronous on rst_n low.
- All slot valid bits clear; all tag registers reset to 0.
- fwd_a_sel and fwd_b_sel reset to 2'b00.
- load_use_stall therefore reads 0.

Slots and tags:
- Four slots: EX, MEM, WB, RET.
- Each slot holds: valid, rd, regwrite, is_load.
- A slot "writes r" when valid=1, regwrite=1, rd==r, and r!=ZERO_REG.

Select encoding (matches the mux data inputs):
- 00: register-file read data.
- 01: EX/MEM ALU result.
- 10: MEM/WB writeback value.
- 11: retired-writeback hold register. This covers a register file without write-through.

Select computation, registered, evaluated at the edge where ID advances into EX:
- For each source rs, search youngest first:
  - Current EX slot writes rs -> 01 (that instruction will be in MEM).
  - Else current MEM slot writes rs -> 10.
  - Else current WB slot writes rs -> 11.
  - Else 00.
- rs==ZERO_REG always gives 00.

Load-use hazard:
- load_use_stall is combinational. It is 1 when all of these hold:
  - id_valid=1;
  - the EX slot is valid, is_load=1 and regwrite=1;
  - EX rd equals id_rs1 or id_rs2, and that rd is not ZERO_REG;
  - hold=0 and flush=0.
- Latency: same cycle as the condition.

Advance rules per rising edge, in priority order:
1. hold=1: every slot, fwd_a_sel and fwd_b_sel hold their values. load_use_stall is forced to 0.
2. flush=1:
   - MEM<-EX is still taken, as the older instruction is not killed. WB<-MEM and RET<-WB also shift.
   - The new EX slot becomes invalid.
   - Selects go to 00.
   - Flush overrides load_use_stall.
3. load_use_stall=1:
   - MEM, WB and RET shift normally.
   - EX becomes a bubble (valid=0); the ID instruction is not consumed.
   - Selects go to 00.
   - On the next cycle the load has moved to MEM, so the search yields 10 and the stall drops.
4. Otherwise:
   - EX<-ID tags, with valid=id_valid.
   - MEM<-EX, WB<-MEM, RET<-WB.
   - Selects are updated per the search above. They are computed only when id_valid=1, else 00.

Boundary cases:
- Both operands may match different slots independently, e.g. A=01 and B=10.
- If several slots write the same rd, the youngest wins.
- Reset asserted mid-stream discards all tags immediately. The first instruction after rst_n rises sees 00.
- A bubble (valid=0) never matches, even if its rd is nonzero.

Test Plan:
- Reset: rst_n=0 mid-run with EX holding rd=5 -> selects 00, load_use_stall 0. After release, ID rs1=5 -> fwd_a_sel 00.
- Back-to-back ALU: I1 rd=3 regwrite, then I2 rs1=3, rs2=3 -> when I2 enters EX, fwd_a_sel=01 and fwd_b_sel=01.
- Distance-2 and distance-3 with priority:
  - I1 rd=4, I2 rd=7, I3 rs1=4, rs2=7 -> A=10, B=01.
  - I1 rd=4, I2 nop, I3 nop, I4 rs1=4 -> A=11.
  - I1 rd=4, I2 rd=4, I3 rs1=4 -> A=01 (youngest wins).
- Load-use: load rd=6, then I2 rs2=6 -> load_use_stall=1 for exactly one cycle, EX gets a bubble, then I2 enters EX with fwd_b_sel=10.
- x0 and bubbles:
  - I1 rd=0 regwrite, I2 rs1=0 -> 00.
  - Load rd=0, then I2 rs1=0 -> no stall.
  - Bubble carrying rd=9 with valid=0 -> no match.
- Hold and flush:
  - hold=1 for 3 cycles during a pending forward -> selects and slots frozen; load_use_stall=0 during hold, then reasserts on release.
  - flush together with a load-use condition -> no stall, EX invalid, selects 00.
